reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 16-entry x 16-bit general-purpose register file for the MISC-V datapath; the storage and read side that consumes values produced by the single-register write path.
- Provides one synchronous write port and two combinational read ports with write-to-read bypass. Register 0 is hardwired to zero.
- Includes a debug dump reader that streams every register out over a valid/ready handshake for bench and trace inspection.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register index width
- NUM_REGS, 16, number of registers; must equal 2**ADDR_W

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- reg_write  in  1  write enable
- write_addr  in  ADDR_W  write index
- write_data  in  DATA_W  write value
- read_addr_a  in  ADDR_W  read port A index
- read_addr_b  in  ADDR_W  read port B index
- read_data_a  out  DATA_W  read port A value (combinational)
- read_data_b  out  DATA_W  read port B value (combinational)
- dump_start  in  1  request a full dump; sampled only in IDLE
- dump_ready  in  1  consumer accepts the current beat
- dump_valid  out  1  beat present on dump_addr/dump_data
- dump_addr  out  ADDR_W  index of the current beat
- dump_data  out  DATA_W  snapshot value of the current beat
- dump_busy  out  1  high in SEND and DONE
- dump_done  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset asserted (asynchronous, any time, including mid-dump):
  - all registers clear to 0
  - FSM goes to IDLE; index clears to 0
  - dump_valid, dump_busy, dump_done, dump_addr and dump_data all go to 0
- Write:
  - on a rising edge with reg_write=1 and write_addr!=0, reg[write_addr] <= write_data
  - writes to index 0 are discarded; reg 0 always reads 0
- Read:
  - read_data_x = 0 if read_addr_x==0
  - otherwise write_data if reg_write=1 and write_addr==read_addr_x (bypass, same cycle)
  - otherwise reg[read_addr_x]
  - zero read latency on both ports
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE, dump_start=1: next state SEND; index<=0; dump_data<=0 (reg 0); dump_valid<=1. dump_start is ignored in every other state.
  - SEND: dump_valid=1. dump_addr and dump_data hold stable while dump_ready=0, and writes to the presented index do not change dump_data.
  - SEND, transfer (dump_valid & dump_ready):
    - index!=NUM_REGS-1: index<=index+1; dump_data<=bypassed value of reg[index+1], using the same bypass rule as the read ports against the write occurring in that same cycle.
    - index==NUM_REGS-1: next state DONE; dump_valid<=0.
  - DONE: dump_done=1 for exactly one cycle; next state IDLE.
- The minimum dump is 17 cycles: 16 beats plus 1 DONE cycle.
- Writes continue normally during a dump. A write to an index already streamed is not reflected in the dump. A write to an index not yet streamed is reflected.
- Index arithmetic is ADDR_W bits; no wrap occurs because SEND exits at NUM_REGS-1.

Decomposition:
- Shared package (misc_v_pkg) holds:
  - DATA_W/ADDR_W constants
  - the dump FSM state enum {IDLE, SEND, DONE}
  - the REG_ZERO index constant
- One sub-module, reg_file_dump, contains the FSM, index counter and snapshot register. It reads the array through a bypassed lookup function supplied by the top level.
- The storage array and read ports stay in reg_file.

Test Plan:
- Reset: hold reset=1 for 2 cycles mid-operation, then release -> read_data_a/b=0x0000 for every index; dump_valid=0; dump_busy=0.
- Write/read: write 0x8888 to r3, then read r3 on port A and r0 on port B -> A=0x8888, B=0x0000. Write 0xFFFF to r0, then read r0 -> 0x0000.
- Bypass: in the same cycle set reg_write=1, write_addr=5, write_data=0x1234, read_addr_a=5 -> read_data_a=0x1234 before the edge; r5=0x1234 after it.
- Dump, ready always 1: preload rN=0x0100+N for N=1..15, pulse dump_start -> beats (0,0x0000), (1,0x0101) ... (15,0x010F) on consecutive cycles; dump_done pulses 1 cycle after the last beat; dump_busy is high for 17 cycles.
- Backpressure: hold dump_ready=0 for 3 cycles on beat 4 while writing 0xBEEF to r4 -> dump_data stays 0x0104 throughout. A write of 0xCAFE to r9 before beat 9 -> beat 9 carries 0xCAFE.
- Reset mid-dump: assert reset during beat 7 -> FSM returns to IDLE; all outputs 0. A later dump_start restarts the dump at index 0.

Source files
------------

// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V register file slice.
//   DATA_W / ADDR_W / NUM_REGS : register width, index width, register count
//   dump_state_t               : debug dump FSM states
//   REG_ZERO / REG_LAST        : hardwired-zero index and last index
//   bypass_read()              : read-port value selection with write bypass,
//                                shared by both read ports and the dump reader
package misc_v_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(NUM_REGS - 1);

    // Register 0 always reads zero; otherwise a write landing on the same
    // index this cycle wins over the stored value.
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] result;
        if (addr == REG_ZERO) begin
            result = '0;
        end else if (we && (waddr == addr)) begin
            result = wdata;
        end else begin
            result = stored;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_file_dump.sv
// Debug dump reader: streams registers 0..NUM_REGS-1 over valid/ready.
//   CLK, reset          : clock, asynchronous active-high reset
//   dump_start          : start request, only honoured in IDLE
//   dump_ready          : consumer accepts the current beat
//   peek_addr/peek_data : lookup of the next index; the top returns the
//                         bypassed register value for that index
//   dump_valid/addr/data: current beat (data is a snapshot register)
//   dump_busy           : high in SEND and DONE
//   dump_done           : one-cycle pulse after the last beat
module reg_file_dump
    import misc_v_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] peek_addr,
    input  logic [DATA_W-1:0] peek_data,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    dump_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [DATA_W-1:0] data_reg,  data_next;

    // Wraps at the last index, but the value is unused there because SEND
    // exits instead of advancing.
    assign peek_addr = index_reg + ADDR_W'(1);

    // State register together with the index counter and snapshot.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            index_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            data_reg  <= data_next;
        end
    end

    // Next-state logic. The snapshot only moves on a transfer, so writes to
    // the presented index during backpressure do not disturb the beat.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        data_next  = data_reg;
        unique case (state_reg)
            IDLE: begin
                if (dump_start) begin
                    state_next = SEND;
                    index_next = REG_ZERO;
                    data_next  = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (index_reg == REG_LAST) begin
                        state_next = DONE;
                    end else begin
                        index_next = peek_addr;
                        data_next  = peek_data;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        dump_valid = (state_reg == SEND);
        dump_busy  = (state_reg != IDLE);
        dump_done  = (state_reg == DONE);
        dump_addr  = index_reg;
        dump_data  = data_reg;
    end

endmodule

// File: rtl/reg_file.sv
// 16 x 16-bit register file: one synchronous write port, two combinational
// read ports with same-cycle write bypass, register 0 hardwired to zero, and
// a debug dump reader.
//   CLK, reset                      : clock, asynchronous active-high reset
//   reg_write/write_addr/write_data : write port
//   read_addr_a/read_data_a         : read port A (zero latency)
//   read_addr_b/read_data_b         : read port B (zero latency)
//   dump_*                          : debug dump stream, see reg_file_dump
module reg_file
    import misc_v_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    logic [NUM_REGS-1:0][DATA_W-1:0] reg_bank;
    logic [ADDR_W-1:0]               peek_addr;
    logic [DATA_W-1:0]               peek_data;

    // Register 0 has no storage at all.
    assign reg_bank[0] = '0;

    // Storage must clear on asynchronous reset, so each entry is its own
    // flop group rather than a RAM.
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] value_reg;

            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (reg_write && (write_addr == ADDR_W'(gi))) begin
                    value_reg <= write_data;
                end
            end

            assign reg_bank[gi] = value_reg;
        end
    endgenerate

    assign read_data_a = bypass_read(read_addr_a, reg_bank[read_addr_a],
                                     reg_write, write_addr, write_data);
    assign read_data_b = bypass_read(read_addr_b, reg_bank[read_addr_b],
                                     reg_write, write_addr, write_data);

    // The dump reader sees the same bypassed view as the read ports, so a
    // write to the next index in the transfer cycle lands in the snapshot.
    assign peek_data   = bypass_read(peek_addr, reg_bank[peek_addr],
                                     reg_write, write_addr, write_data);

    reg_file_dump u_dump (
        .CLK        (CLK),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .peek_addr  (peek_addr),
        .peek_data  (peek_data),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        CLK;
    logic        reset;
    logic        reg_write;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic [3:0]  read_addr_a;
    logic [3:0]  read_addr_b;
    logic [15:0] read_data_a;
    logic [15:0] read_data_b;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [3:0]  dump_addr;
    logic [15:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } beat_t;

    beat_t       sb[$];
    logic [15:0] model [16];
    int          errors = 0;
    int          checks = 0;
    int          busy_cycles;
    int          done_cycle;
    int          done_count;

    reg_file dut (
        .CLK         (CLK),
        .reset       (reset),
        .reg_write   (reg_write),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_addr_a (read_addr_a),
        .read_addr_b (read_addr_b),
        .read_data_a (read_data_a),
        .read_data_b (read_data_b),
        .dump_start  (dump_start),
        .dump_ready  (dump_ready),
        .dump_valid  (dump_valid),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .dump_busy   (dump_busy),
        .dump_done   (dump_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        reg_write  = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        reg_write  = 1'b0;
        if (a != 4'd0) model[a] = d;
    endtask

    task automatic push_model();
        for (int i = 0; i < 16; i++) begin
            sb.push_back({4'(i), model[i]});
        end
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    // Counts busy cycles from the first SEND cycle until IDLE is reached.
    task automatic run_to_idle(output int busy_n, output int done_at, output int done_n);
        busy_n  = 0;
        done_at = -1;
        done_n  = 0;
        for (int n = 0; n < 60; n++) begin
            if (!dump_busy) break;
            busy_n++;
            if (dump_done) begin
                done_n++;
                done_at = n;
            end
            tick();
        end
    endtask

    task automatic wait_beat(input logic [3:0] target);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (dump_valid && dump_addr == target) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("wait_beat_found", 32'(found), 32'd1);
    endtask

    // Scoreboard consumer: a beat is transferred at the next rising edge.
    always @(negedge CLK) begin
        if (!reset && dump_valid && dump_ready) begin
            if (sb.size() == 0) begin
                check("beat_unexpected", {28'd0, dump_addr}, 32'hFFFF_FFFF);
            end else begin
                beat_t exp_beat;
                exp_beat = sb.pop_front();
                check("beat_addr", 32'(dump_addr), 32'(exp_beat.addr));
                check("beat_data", 32'(dump_data), 32'(exp_beat.data));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        reg_write   = 1'b0;
        write_addr  = '0;
        write_data  = '0;
        read_addr_a = '0;
        read_addr_b = '0;
        dump_start  = 1'b0;
        dump_ready  = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        // Reset in the middle of activity, held for two cycles.
        write_reg(4'd7, 16'h7777);
        write_reg(4'd8, 16'h8888);
        reg_write  = 1'b1;
        write_addr = 4'd9;
        write_data = 16'h9999;
        reset      = 1'b1;
        tick();
        tick();
        reg_write  = 1'b0;
        reset      = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            read_addr_a = 4'(i);
            read_addr_b = 4'(15 - i);
            #1;
            check("reset_read_a", 32'(read_data_a), 32'h0);
            check("reset_read_b", 32'(read_data_b), 32'h0);
        end
        check("reset_valid", 32'(dump_valid), 32'd0);
        check("reset_busy", 32'(dump_busy), 32'd0);

        // Plain write and read, including register 0.
        write_reg(4'd3, 16'h8888);
        read_addr_a = 4'd3;
        read_addr_b = 4'd0;
        #1;
        check("read_a_r3", 32'(read_data_a), 32'h8888);
        check("read_b_r0", 32'(read_data_b), 32'h0000);
        write_reg(4'd0, 16'hFFFF);
        read_addr_a = 4'd0;
        #1;
        check("read_r0_after_w", 32'(read_data_a), 32'h0000);

        // Same-cycle bypass on both ports, then the stored value.
        reg_write   = 1'b1;
        write_addr  = 4'd5;
        write_data  = 16'h1234;
        read_addr_a = 4'd5;
        read_addr_b = 4'd5;
        #1;
        check("bypass_a", 32'(read_data_a), 32'h1234);
        check("bypass_b", 32'(read_data_b), 32'h1234);
        tick();
        reg_write = 1'b0;
        model[5]  = 16'h1234;
        #1;
        check("stored_r5", 32'(read_data_a), 32'h1234);

        // Full dump with ready held high.
        for (int n = 1; n < 16; n++) write_reg(4'(n), 16'h0100 + 16'(n));
        push_model();
        start_dump();
        run_to_idle(busy_cycles, done_cycle, done_count);
        check("dump_busy_cycles", 32'(busy_cycles), 32'd17);
        check("dump_done_cycle", 32'(done_cycle), 32'd16);
        check("dump_done_count", 32'(done_count), 32'd1);
        check("dump_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure on beat 4 with a write to r4; later write to r9.
        for (int i = 0; i < 16; i++) begin
            sb.push_back({4'(i), (i == 9) ? 16'hCAFE : model[i]});
        end
        start_dump();
        wait_beat(4'd4);
        dump_ready = 1'b0;
        reg_write  = 1'b1;
        write_addr = 4'd4;
        write_data = 16'hBEEF;
        for (int n = 0; n < 3; n++) begin
            check("bp_hold_addr", 32'(dump_addr), 32'd4);
            check("bp_hold_data", 32'(dump_data), 32'h0104);
            tick();
        end
        model[4]   = 16'hBEEF;
        dump_ready = 1'b1;
        write_addr = 4'd9;
        write_data = 16'hCAFE;
        tick();
        reg_write  = 1'b0;
        model[9]   = 16'hCAFE;
        run_to_idle(busy_cycles, done_cycle, done_count);
        check("bp_done_count", 32'(done_count), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        read_addr_a = 4'd4;
        read_addr_b = 4'd9;
        #1;
        check("bp_r4", 32'(read_data_a), 32'hBEEF);
        check("bp_r9", 32'(read_data_b), 32'hCAFE);

        // Reset during beat 7, then a fresh dump.
        for (int i = 0; i < 7; i++) sb.push_back({4'(i), model[i]});
        start_dump();
        wait_beat(4'd7);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(dump_valid), 32'd0);
        check("mid_rst_busy", 32'(dump_busy), 32'd0);
        check("mid_rst_done", 32'(dump_done), 32'd0);
        check("mid_rst_addr", 32'(dump_addr), 32'd0);
        check("mid_rst_data", 32'(dump_data), 32'd0);
        check("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        read_addr_a = 4'd5;
        #1;
        check("mid_rst_r5", 32'(read_data_a), 32'h0);
        write_reg(4'd2, 16'h2222);
        push_model();
        start_dump();
        check("restart_addr", 32'(dump_addr), 32'd0);
        run_to_idle(busy_cycles, done_cycle, done_count);
        check("restart_busy", 32'(busy_cycles), 32'd17);
        check("restart_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
